// File: rtl/dct_row_loader.sv
// Serial-to-parallel row loader for an 8x8 DCT: collects 8 pixels into a row and presents
// them on a..h with a valid/ready handshake. Define LEVEL_SHIFT_EN to store pixels as pix^0x80.
module dct_row_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] c,
    output logic [7:0] d,
    output logic [7:0] e,
    output logic [7:0] f,
    output logic [7:0] g,
    output logic [7:0] h,
    output logic       row_valid,
    input  logic       row_ready,
    output logic [2:0] row_idx,
    output logic       blk_last
);

    typedef enum logic {StFill, StWait} state_t;

    state_t     state;
    logic [7:0] fill [8];
    logic [2:0] col;
    logic       accept;
    logic       handover;
    logic [7:0] pix_st;

    always_comb begin
        pix_ready = !rst && (state == StFill);
        accept    = pix_valid && pix_ready;
        handover  = row_valid && row_ready;
        blk_last  = row_valid && (row_idx == 3'd7);
`ifdef LEVEL_SHIFT_EN
        pix_st    = pix_in ^ 8'h80;
`else
        pix_st    = pix_in;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StFill;
            col       <= 3'd0;
            row_valid <= 1'b0;
            row_idx   <= 3'd0;
            a         <= 8'd0;
            b         <= 8'd0;
            c         <= 8'd0;
            d         <= 8'd0;
            e         <= 8'd0;
            f         <= 8'd0;
            g         <= 8'd0;
            h         <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                fill[i] <= 8'd0;
            end
        end else begin
            if (handover) begin
                row_idx <= row_idx + 3'd1;
            end
            unique case (state)
                StFill: begin
                    if (accept) begin
                        fill[col] <= pix_st;
                        col       <= col + 3'd1;
                    end
                    if (accept && col == 3'd7) begin
                        // Output free: bypass the 8th pixel straight into h.
                        if (!row_valid || row_ready) begin
                            a         <= fill[0];
                            b         <= fill[1];
                            c         <= fill[2];
                            d         <= fill[3];
                            e         <= fill[4];
                            f         <= fill[5];
                            g         <= fill[6];
                            h         <= pix_st;
                            row_valid <= 1'b1;
                        end else begin
                            state <= StWait;
                        end
                    end else if (handover) begin
                        row_valid <= 1'b0;
                    end
                end
                StWait: begin
                    if (handover) begin
                        a     <= fill[0];
                        b     <= fill[1];
                        c     <= fill[2];
                        d     <= fill[3];
                        e     <= fill[4];
                        f     <= fill[5];
                        g     <= fill[6];
                        h     <= fill[7];
                        state <= StFill;
                        col   <= 3'd0;
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

endmodule
